serial_sub4: RTL and testbench
==============================

// Module: serial_sub4
// PURPOSE
//  Bit-serial unsigned subtractor, the inverse operation to the parallel 4-bit adder.
//  Computes d = a - b LSB-first, one bit per clock, using a single borrow flip-flop.
//  Input and output use valid/ready handshakes, so it drops into the same bench/datapath
//  flow as adder4 (e.g. result check: adder4(d, b) == a when borrow==0).
// PARAMETERS
//  WIDTH  4  operand/result width in bits (>=2)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      a/b operands valid
//  in_ready   out  1      block can accept operands
//  a          in   WIDTH  minuend (unsigned)
//  b          in   WIDTH  subtrahend (unsigned)
//  out_valid  out  1      d/borrow valid
//  out_ready  in   1      consumer accepts result
//  d          out  WIDTH  (a - b) mod 2^WIDTH
//  borrow     out  1      1 iff a < b (unsigned)
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, in_ready=1, out_valid=0, d=0, borrow=0,
//   internal shift regs/counter/borrow ff = 0. Reset mid-SHIFT or mid-DONE aborts; no output.
//  FSM states:
//   IDLE : in_ready=1, out_valid=0. in_valid&in_ready at edge -> load a_sh=a, b_sh=b,
//          bor=0, cnt=0; -> SHIFT.
//   SHIFT: in_ready=0. Each edge: x=a_sh[0], y=b_sh[0];
//          dbit = x^y^bor; bor <= (~x&y) | (~(x^y)&bor);
//          d_sh <= {dbit, d_sh[WIDTH-1:1]}; a_sh,b_sh shift right 1; cnt++.
//          When cnt==WIDTH-1 at edge: -> DONE, load d<=final d_sh, borrow<=final bor.
//   DONE : out_valid=1, in_ready=0; d/borrow held stable. out_valid&out_ready at edge -> IDLE.
//  Latency: operands accepted at edge E0; out_valid high after edge E_WIDTH (WIDTH cycles).
//  Throughput: one result per WIDTH+2 cycles max (accept, WIDTH shift, 1 handshake cycle).
//  in_ready/out_valid are decoded from registered state only (no comb path from in/out ports).
//  in_valid while not IDLE: ignored; a/b changes during SHIFT have no effect.
//  out_ready low in DONE: stall indefinitely, d/borrow unchanged.
//  After DONE->IDLE, d/borrow keep last result; out_valid=0 marks them stale.
//  No simultaneous accept+deliver: IDLE and DONE are disjoint states.
//  Arithmetic: exact modular WIDTH-bit subtraction; no saturation; borrow is the final
//   borrow-out, equivalently a < b.
// TESTING
//  1. a=5,b=3, out_ready=1 -> out_valid after 4 cycles, d=2, borrow=0.
//  2. a=3,b=5 -> d=14 (4'b1110), borrow=1; a=0,b=15 -> d=1, borrow=1.
//  3. a=0,b=0 and a=15,b=0 -> d=0/borrow=0 and d=15/borrow=0; in_ready back to 1 after accept.
//  4. Back-pressure: a=13,b=7, out_ready=0 for 10 cycles -> out_valid stays 1, d=6 stable;
//     raise out_ready -> next cycle out_valid=0, in_ready=1.
//  5. Busy: assert in_valid with a=9,b=1 during SHIFT of a=2,b=1 -> ignored, result d=1;
//     in_ready=0 throughout SHIFT/DONE.
//  6. Reset: drop rst_n mid-SHIFT (no clock edge needed) -> immediately out_valid=0, d=0,
//     borrow=0, in_ready=1; next op a=10,b=4 gives d=6. Exhaustive 256-pair sweep vs a-b.

Source files
------------

// File: rtl/serial_sub4_if.sv
// Handshake bundle for the bit-serial subtractor: operand channel (a/b) and
// result channel (d/borrow), each with its own valid/ready pair.
interface serial_sub4_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             borrow;

  // Producer of operands / consumer of results
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, d, borrow
  );

  // The subtractor itself
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, d, borrow
  );
endinterface

// File: rtl/serial_sub4.sv
// Bit-serial unsigned subtractor: d = (a - b) mod 2^WIDTH, borrow = (a < b).
// One bit per clock, LSB first, through a single borrow flip-flop.
// Operands are taken in IDLE, shifted for WIDTH cycles, then held in DONE
// until the consumer takes them. Handshake outputs decode from state only.
module serial_sub4 #(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_sub4_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] d_sh;
  logic             bor;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] d_q;
  logic             borrow_q;
  logic             dbit;
  logic             bor_next;

  // One-bit full subtractor; returns {borrow_out, difference}.
  function automatic logic [1:0] sub_bit(input logic x, input logic y, input logic bin);
    sub_bit = {(~x & y) | (~(x ^ y) & bin), x ^ y ^ bin};
  endfunction

  assign {bor_next, dbit} = sub_bit(a_sh[0], b_sh[0], bor);

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.d         = d_q;
  assign bus.borrow    = borrow_q;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: accept in IDLE, count WIDTH shifts, wait for consumer in DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_next = SHIFT;
      SHIFT:   if (cnt == LAST)   state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  // Serial datapath: load operands, then shift one difference bit per cycle;
  // the finished word and borrow are captured on the last shift and held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      d_sh     <= '0;
      bor      <= 1'b0;
      cnt      <= '0;
      d_q      <= '0;
      borrow_q <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.in_valid) begin
        a_sh <= bus.a;
        b_sh <= bus.b;
        bor  <= 1'b0;
        cnt  <= '0;
      end
    end else if (state == SHIFT) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      d_sh <= {dbit, d_sh[WIDTH-1:1]};
      bor  <= bor_next;
      cnt  <= cnt + CW'(1);
      if (cnt == LAST) begin
        d_q      <= {dbit, d_sh[WIDTH-1:1]};
        borrow_q <= bor_next;
      end
    end
  end

endmodule

// File: tb/tb_serial_sub4.sv
// Bench for serial_sub4: directed operations with literal expectations plus a
// transaction-level model (result = a-b mod 16, ready when nothing pending,
// valid WIDTH cycles after accept) compared against the outputs every cycle.
module tb_serial_sub4;
  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  serial_sub4_if #(.WIDTH(WIDTH)) bus ();

  serial_sub4 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: one outstanding operation at most.
  logic             pend;
  int               age;
  logic [WIDTH-1:0] pend_d;
  logic             pend_b;
  logic [WIDTH-1:0] held_d;
  logic             held_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend   <= 1'b0;
      age    <= 0;
      held_d <= '0;
      held_b <= 1'b0;
    end else if (!pend) begin
      if (bus.in_valid) begin
        pend   <= 1'b1;
        age    <= 0;
        pend_d <= WIDTH'(int'(bus.a) - int'(bus.b));
        pend_b <= (bus.a < bus.b);
      end
    end else if (age < WIDTH) begin
      age <= age + 1;
      if (age == WIDTH - 1) begin
        held_d <= pend_d;
        held_b <= pend_b;
      end
    end else if (bus.out_ready) begin
      pend <= 1'b0;
    end
  end

  // Compare outputs with the model on every falling edge out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_in_ready", bus.in_ready, !pend);
      chk("model_out_valid", bus.out_valid, (pend && age >= WIDTH));
      chk("model_d", bus.d, held_d);
      chk("model_borrow", bus.borrow, held_b);
    end
  end

  // Present operands for one cycle; caller is at posedge+1 with in_ready high.
  task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    bus.in_valid = 1'b1;
    bus.a = av;
    bus.b = bv;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(input int exp_lat);
    int n;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, exp_lat);
  endtask

  task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input int ed, input int eb);
    send(av, bv);
    chk("busy_in_ready", bus.in_ready, 0);
    wait_result(WIDTH);
    chk("op_d", bus.d, ed);
    chk("op_borrow", bus.borrow, eb);
    @(posedge clk); #1;
    chk("post_out_valid", bus.out_valid, 0);
    chk("post_in_ready", bus.in_ready, 1);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_d", bus.d, 0);
    chk("rst_borrow", bus.borrow, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic and wrap-around cases
    do_op(4'd5, 4'd3, 2, 0);
    do_op(4'd3, 4'd5, 14, 1);
    do_op(4'd0, 4'd15, 1, 1);
    do_op(4'd0, 4'd0, 0, 0);
    do_op(4'd15, 4'd0, 15, 0);

    // Back-pressure: result held while out_ready is low
    bus.out_ready = 1'b0;
    send(4'd13, 4'd7);
    wait_result(WIDTH);
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_d", bus.d, 6);
      chk("stall_in_ready", bus.in_ready, 0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release_valid", bus.out_valid, 0);
    chk("stall_release_ready", bus.in_ready, 1);

    // Busy: new operands during SHIFT are ignored
    send(4'd2, 4'd1);
    bus.in_valid = 1'b1;
    bus.a = 4'd9;
    bus.b = 4'd1;
    for (int i = 0; i < WIDTH - 1; i++) begin
      chk("busy_ignore_ready", bus.in_ready, 0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.a = 4'd7;
    bus.b = 4'd3;
    wait_result(1);
    chk("busy_d", bus.d, 1);
    chk("busy_borrow", bus.borrow, 0);
    @(posedge clk); #1;
    chk("busy_post_ready", bus.in_ready, 1);

    // Asynchronous reset in the middle of SHIFT
    send(4'd6, 4'd2);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_d", bus.d, 0);
    chk("arst_borrow", bus.borrow, 0);
    chk("arst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op(4'd10, 4'd4, 6, 0);

    // Exhaustive sweep of all operand pairs
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        send(WIDTH'(ai), WIDTH'(bi));
        wait_result(WIDTH);
        chk("sweep_d", bus.d, (ai - bi) & 15);
        chk("sweep_borrow", bus.borrow, (ai < bi) ? 1 : 0);
        @(posedge clk); #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
